evict_wb_buffer: RTL

//  Write-back buffer between the 4-way L1 data array and main memory (mm). Cache FSM (WR_EVICT/RD_EVICT)

---
 rtl/cache_pkg.sv | 11 +
 rtl/evict_wb_match.sv | 32 +++
 rtl/evict_wb_buffer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared cache-side definitions for the eviction write-back buffer.
package cache_pkg;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int OFFS_W = 5;
  localparam int DEPTH  = 4;

  typedef logic [ADDR_W-1:OFFS_W] line_addr_t;

  typedef enum logic {EB_IDLE, EB_WRITE} eb_state_t;
endpackage

// File: rtl/evict_wb_match.sv
// Parallel line-address compare across all entries; the youngest match wins.
// Age is the distance from the FIFO read pointer, so the oldest entry (a possibly
// in-flight head) always loses to any newer matching entry.
module evict_wb_match #(
  parameter int DEPTH = 4,
  parameter int LA_W  = 27,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]           valid_i,
  input  logic [DEPTH-1:0][LA_W-1:0] addr_i,
  input  logic [LA_W-1:0]            qaddr_i,
  input  logic [PTR_W-1:0]           base_i,
  output logic                       hit_o,
  output logic [PTR_W-1:0]           idx_o
);
  logic [PTR_W-1:0] age, best;

  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    best  = '0;
    age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age = PTR_W'(i) - base_i;
      if (valid_i[i] && (addr_i[i] == qaddr_i) && (!hit_o || age > best)) begin
        hit_o = 1'b1;
        idx_o = PTR_W'(i);
        best  = age;
      end
    end
  end
endmodule

// File: rtl/evict_wb_buffer.sv
// Write-back buffer for dirty victim lines: FIFO drain to main memory with
// coalescing of repeated victims and a one-cycle lookup for read misses.
module evict_wb_buffer
  import cache_pkg::*;
#(
  parameter int ADDR_W = cache_pkg::ADDR_W,
  parameter int LINE_W = cache_pkg::LINE_W,
  parameter int DEPTH  = cache_pkg::DEPTH,
  parameter int OCC_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              evict_valid,
  output logic              evict_ready,
  input  logic [ADDR_W-1:0] evict_addr,
  input  logic [LINE_W-1:0] evict_data,
  input  logic              lookup_valid,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              lookup_hit,
  output logic [LINE_W-1:0] lookup_data,
  output logic              mm_wr_req,
  output logic [ADDR_W-1:0] mm_wr_addr,
  output logic [LINE_W-1:0] mm_wr_data,
  input  logic              mm_wr_ack,
  input  logic              flush_req,
  output logic              flush_done,
  output logic [OCC_W-1:0]  occupancy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LA_W  = ADDR_W - OFFS_W;

  logic [DEPTH-1:0]             vld_q;
  logic [DEPTH-1:0][LA_W-1:0]   la_q;
  logic [DEPTH-1:0][LINE_W-1:0] data_q;
  logic [PTR_W-1:0]             wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]             occ_q;
  eb_state_t                    st_q, st_d;
  logic                         lk_hit_q, lk_hit_d;
  logic [LINE_W-1:0]            lk_data_q, lk_data_d;

  logic [LA_W-1:0]  ev_la, lk_la;
  logic [DEPTH-1:0] fl_mask;
  logic             push, pop, alloc, full;
  logic             co_hit, lk_ent_hit;
  logic [PTR_W-1:0] co_idx, lk_idx;
  logic             unused_offs;

  assign ev_la       = evict_addr[ADDR_W-1:OFFS_W];
  assign lk_la       = lookup_addr[ADDR_W-1:OFFS_W];
  assign unused_offs = ^{evict_addr[OFFS_W-1:0], lookup_addr[OFFS_W-1:0]};

  assign full        = (occ_q == OCC_W'(DEPTH));
  assign evict_ready = !full && !flush_req;
  assign push        = evict_valid && evict_ready;
  assign pop         = (st_q == EB_WRITE) && mm_wr_ack;
  assign alloc       = push && !co_hit;

  // The head being written must never be modified, so coalescing ignores it.
  always_comb begin
    fl_mask = '0;
    if (st_q == EB_WRITE) fl_mask[rd_ptr_q] = 1'b1;
  end

  evict_wb_match #(.DEPTH(DEPTH), .LA_W(LA_W), .PTR_W(PTR_W)) u_co_match (
    .valid_i (vld_q & ~fl_mask),
    .addr_i  (la_q),
    .qaddr_i (ev_la),
    .base_i  (rd_ptr_q),
    .hit_o   (co_hit),
    .idx_o   (co_idx)
  );

  evict_wb_match #(.DEPTH(DEPTH), .LA_W(LA_W), .PTR_W(PTR_W)) u_lk_match (
    .valid_i (vld_q),
    .addr_i  (la_q),
    .qaddr_i (lk_la),
    .base_i  (rd_ptr_q),
    .hit_o   (lk_ent_hit),
    .idx_o   (lk_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      la_q     <= '0;
      data_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (pop) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + 1'b1;
      end
      if (push) begin
        if (co_hit) begin
          data_q[co_idx] <= evict_data;
        end else begin
          vld_q[wr_ptr_q]  <= 1'b1;
          la_q[wr_ptr_q]   <= ev_la;
          data_q[wr_ptr_q] <= evict_data;
          wr_ptr_q         <= wr_ptr_q + 1'b1;
        end
      end
      occ_q <= occ_q + OCC_W'(alloc) - OCC_W'(pop);
    end
  end

  // Drain FSM: always passes through IDLE after an ack so mm_wr_req drops for a cycle.
  always_comb begin
    st_d       = st_q;
    mm_wr_req  = 1'b0;
    mm_wr_addr = '0;
    mm_wr_data = '0;
    case (st_q)
      EB_IDLE: begin
        if (occ_q != '0) st_d = EB_WRITE;
      end
      EB_WRITE: begin
        mm_wr_req  = 1'b1;
        mm_wr_addr = {la_q[rd_ptr_q], {OFFS_W{1'b0}}};
        mm_wr_data = data_q[rd_ptr_q];
        if (mm_wr_ack) st_d = EB_IDLE;
      end
      default: st_d = EB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= EB_IDLE;
    else        st_q <= st_d;
  end

  // A same-cycle push carries the newest data for its line, so it outranks storage.
  always_comb begin
    lk_hit_d  = 1'b0;
    lk_data_d = lk_data_q;
    if (lookup_valid) begin
      if (push && (ev_la == lk_la)) begin
        lk_hit_d  = 1'b1;
        lk_data_d = evict_data;
      end else if (lk_ent_hit) begin
        lk_hit_d  = 1'b1;
        lk_data_d = data_q[lk_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_hit_q  <= 1'b0;
      lk_data_q <= '0;
    end else begin
      lk_hit_q  <= lk_hit_d;
      lk_data_q <= lk_data_d;
    end
  end

  assign lookup_hit  = lk_hit_q;
  assign lookup_data = lk_data_q;
  assign occupancy   = occ_q;
  assign flush_done  = flush_req && (occ_q == '0) && (st_q == EB_IDLE);
endmodule
